fp32_mul_pipe: RTL and testbench
================================

// Module: fp32_mul_pipe
// PURPOSE
//  Pipelined IEEE-754 single-precision multiplier; the stage directly upstream of the ACC accumulator in the MAC datapath.
//  Takes operand pairs over a valid/ready handshake and emits products into ACC.DataIn over the same handshake.
//  Elastic pipeline: bubbles collapse, backpressure from ACC stalls only the stages that are full.
// PARAMETERS
//  DataWidth        32  operand/result width; only 32 is legal (binary32)
//  Pipeline_Stages  3   register stages, legal >=3; stages beyond 3 are plain elastic delay slots after rounding
// PORTS
//  clk           in   1   single clock, rising edge
//  aclr          in   1   asynchronous, active-high reset
//  DataInValid   in   1   operand pair valid
//  DataInRdy     out  1   pipeline can accept; transfer when DataInValid & DataInRdy
//  DataInA       in   32  operand A, binary32
//  DataInB       in   32  operand B, binary32
//  DataOutValid  out  1   product valid (drives ACC DataInValid)
//  DataOutRdy    in   1   consumer ready (from ACC DataInRdy)
//  DataOut       out  32  product A*B, binary32
// BEHAVIOUR
//  Reset: aclr clears every stage valid bit immediately; DataOutValid=0, DataOut=32'h0, all data regs 0; DataInRdy=1 after release.
//  Latency: Pipeline_Stages cycles accept->DataOutValid with no stall; throughput 1/cycle when DataOutRdy=1.
//  Handshake: stage i loads when (!valid_i | advance_i+1); last stage advances on DataOutRdy.
//   DataInRdy = !valid_0 | advance_1 (combinational from DataOutRdy chain, no extra register).
//   DataOut/DataOutValid are registered and held stable while DataOutValid & !DataOutRdy.
//   Order preserved; no drop or duplication under any stall pattern. Full pipe: DataInRdy=0 until DataOutRdy=1.
//  Stage 1 (unpack): split sign/exp/mant; exp==0 -> operand treated as signed zero (denormal flush);
//   classify NaN (exp=255, mant!=0), Inf (exp=255, mant=0), Zero.
//  Stage 2 (multiply): 24x24 -> 48-bit mantissa product, exponent = ea+eb-127 in 10-bit signed, sign = sa^sb.
//  Stage 3 (normalize/round): if prod[47] shift right 1, exp+1; round-to-nearest-even using guard/round/sticky;
//   mantissa carry-out on rounding renormalizes (exp+1).
//   Final exp >=255 -> signed Inf (sign,8'hFF,23'h0); final exp <=0 -> signed zero (no denormal output).
//  Specials (override arithmetic): any NaN -> 32'h7FC0_0000; Inf*Zero -> 32'h7FC0_0000;
//   Inf*nonzero -> signed Inf; Zero*finite -> signed zero (sign = sa^sb).
//  Reset mid-operation: in-flight items discarded, no output after release until new input accepted.
//  Simultaneous DataInValid and full pipe draining: accept in the same cycle the last stage advances.
// STRUCTURE
//  fp32_pkg: field widths, EXP_BIAS=127, QNAN=32'h7FC0_0000, POS_INF=32'h7F80_0000, class encoding constants.
//  Sub-module fp32_pipe_slot: one elastic register slot (valid, payload, load/advance); instanced per stage
//   and via generate for stages 4..Pipeline_Stages.
//  Arithmetic between slots stays in fp32_mul_pipe.
// TESTING
//  T1 A=43C8_8000 (401.0), B=3F80_0000 (1.0), DataOutRdy=1 -> DataOut=43C8_8000 exactly 3 cycles after accept.
//  T2 4000_0000*4040_0000 -> 40C0_0000; 3F80_0001*3F80_0001 -> 3F80_0002 (RNE, sticky).
//  T3 7F00_0000*4000_0000 -> 7F80_0000; 0080_0000*3F00_0000 -> 0000_0000; 7F80_0000*0000_0000 -> 7FC0_0000;
//     FFC0_0001*3F80_0000 -> 7FC0_0000; 8000_0000*3F80_0000 -> 8000_0000.
//  T4 DataOutRdy=0, 5 back-to-back inputs -> exactly 3 accepted, DataInRdy=0, DataOut held stable;
//     DataOutRdy=1 -> 3 products in order, remaining 2 then accepted, none lost or duplicated.
//  T5 Random valid/ready toggling, 1000 pairs vs. reference model (flush/RNE rules) -> bit-exact, in order.
//  T6 aclr asserted with 2 items in flight -> DataOutValid=0 immediately; no stale output after release.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared field widths, special encodings and stage payload types for the
// pipelined binary32 multiplier.
package fp32_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned EXP_W  = 8;
   localparam int unsigned MAN_W  = 23;
   localparam int unsigned SIG_W  = MAN_W + 1;
   localparam int unsigned PROD_W = 2 * SIG_W;
   localparam int unsigned SEXP_W = 10;

   localparam logic [EXP_W-1:0]         EXP_BIAS  = 8'd127;
   localparam logic [EXP_W-1:0]         EXP_MAX   = 8'hFF;
   localparam logic signed [SEXP_W-1:0] SEXP_INF  = 10'sd255;
   localparam logic signed [SEXP_W-1:0] SEXP_ZERO = 10'sd0;
   localparam logic [WORD_W-1:0]        QNAN      = 32'h7FC0_0000;
   localparam logic [WORD_W-1:0]        POS_INF   = 32'h7F80_0000;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } fp_class_e;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] sig;
      fp_class_e        cls;
   } fp_op_t;

   typedef struct packed {
      fp_op_t a;
      fp_op_t b;
   } unpack_t;

   typedef struct packed {
      logic              sign;
      logic [SEXP_W-1:0] exp;
      logic [PROD_W-1:0] prod;
      fp_class_e         cls_a;
      fp_class_e         cls_b;
   } mult_t;

   // Denormal inputs are flushed to signed zero here.
   function automatic fp_op_t fp_unpack(input logic [WORD_W-1:0] x);
      fp_op_t r;
      r.sign = x[WORD_W-1];
      r.exp  = x[WORD_W-2 -: EXP_W];
      r.sig  = {1'b1, x[MAN_W-1:0]};
      r.cls  = CLS_NORM;
      if (r.exp == '0) begin
         r.cls = CLS_ZERO;
         r.sig = '0;
      end else if (r.exp == EXP_MAX) begin
         r.cls = (x[MAN_W-1:0] != '0) ? CLS_NAN : CLS_INF;
      end
      return r;
   endfunction

endpackage

// File: rtl/fp32_mul_pipe_if.sv
// Operand/product valid-ready bus between the upstream source, the
// multiplier and the ACC accumulator.
interface fp32_mul_pipe_if;
   import fp32_pkg::*;

   logic              DataInValid;
   logic              DataInRdy;
   logic [WORD_W-1:0] DataInA;
   logic [WORD_W-1:0] DataInB;
   logic              DataOutValid;
   logic              DataOutRdy;
   logic [WORD_W-1:0] DataOut;

   modport slave (
      input  DataInValid, DataInA, DataInB, DataOutRdy,
      output DataInRdy, DataOutValid, DataOut
   );

   modport master (
      output DataInValid, DataInA, DataInB, DataOutRdy,
      input  DataInRdy, DataOutValid, DataOut
   );

endinterface

// File: rtl/fp32_pipe_slot.sv
// One elastic pipeline register: loads whenever empty or when the
// downstream slot takes the current item in the same cycle.
module fp32_pipe_slot #(
   parameter type payload_t = logic
) (
   input  logic     clk,
   input  logic     aclr,
   input  logic     in_valid,
   input  payload_t in_data,
   output logic     in_rdy_c,
   output logic     out_valid,
   output payload_t out_data,
   input  logic     out_rdy
);

   logic     valid_q, valid_d;
   payload_t data_q, data_d;

   assign in_rdy_c  = !valid_q || out_rdy;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_rdy_c) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/fp32_mul_pipe.sv
// Pipelined binary32 multiplier: unpack -> 24x24 multiply -> normalize/round,
// each followed by an elastic slot, plus optional delay slots on the result.
module fp32_mul_pipe
   import fp32_pkg::*;
#(
   parameter int unsigned DataWidth       = 32,
   parameter int unsigned Pipeline_Stages = 3
) (
   input  logic           clk,
   input  logic           aclr,
   fp32_mul_pipe_if.slave bus
);

   localparam int unsigned NUM_TAIL = Pipeline_Stages - 3;

   unpack_t              unp_c, s1_pld;
   mult_t                mult_c, s2_pld;
   logic                 s1_vld, s2_vld, s2_rdy_c, s3_rdy_c;
   logic [DataWidth-1:0] result_c;

   logic                 tail_vld   [NUM_TAIL+1];
   logic [DataWidth-1:0] tail_pld   [NUM_TAIL+1];
   logic                 tail_rdy_c [NUM_TAIL+1];

   always_comb begin
      unp_c.a = fp_unpack(bus.DataInA);
      unp_c.b = fp_unpack(bus.DataInB);
   end

   fp32_pipe_slot #(.payload_t(unpack_t)) u_slot_unpack (
      .clk      (clk),
      .aclr     (aclr),
      .in_valid (bus.DataInValid),
      .in_data  (unp_c),
      .in_rdy_c (bus.DataInRdy),
      .out_valid(s1_vld),
      .out_data (s1_pld),
      .out_rdy  (s2_rdy_c)
   );

   // Biased exponent sum kept signed in 10 bits so over/underflow stay visible.
   always_comb begin
      mult_c.sign  = s1_pld.a.sign ^ s1_pld.b.sign;
      mult_c.exp   = SEXP_W'(s1_pld.a.exp) + SEXP_W'(s1_pld.b.exp) - SEXP_W'(EXP_BIAS);
      mult_c.prod  = PROD_W'(s1_pld.a.sig) * PROD_W'(s1_pld.b.sig);
      mult_c.cls_a = s1_pld.a.cls;
      mult_c.cls_b = s1_pld.b.cls;
   end

   fp32_pipe_slot #(.payload_t(mult_t)) u_slot_mult (
      .clk      (clk),
      .aclr     (aclr),
      .in_valid (s1_vld),
      .in_data  (mult_c),
      .in_rdy_c (s2_rdy_c),
      .out_valid(s2_vld),
      .out_data (s2_pld),
      .out_rdy  (s3_rdy_c)
   );

   logic                     shift, guard, sticky, round_up;
   logic [MAN_W-1:0]         frac;
   logic [SIG_W-1:0]         frac_rnd;
   logic signed [SEXP_W-1:0] exp_fin;
   logic                     any_nan, any_inf, any_zero;

   // Normalize, round-to-nearest-even, then let special operands override.
   always_comb begin
      shift = s2_pld.prod[PROD_W-1];
      if (shift) begin
         frac   = s2_pld.prod[PROD_W-2 -: MAN_W];
         guard  = s2_pld.prod[PROD_W-2-MAN_W];
         sticky = |s2_pld.prod[PROD_W-3-MAN_W:0];
      end else begin
         frac   = s2_pld.prod[PROD_W-3 -: MAN_W];
         guard  = s2_pld.prod[PROD_W-3-MAN_W];
         sticky = |s2_pld.prod[PROD_W-4-MAN_W:0];
      end
      round_up = guard && (sticky || frac[0]);
      frac_rnd = {1'b0, frac} + SIG_W'(round_up);
      exp_fin  = s2_pld.exp + SEXP_W'(shift) + SEXP_W'(frac_rnd[MAN_W]);

      any_nan  = (s2_pld.cls_a == CLS_NAN)  || (s2_pld.cls_b == CLS_NAN);
      any_inf  = (s2_pld.cls_a == CLS_INF)  || (s2_pld.cls_b == CLS_INF);
      any_zero = (s2_pld.cls_a == CLS_ZERO) || (s2_pld.cls_b == CLS_ZERO);

      result_c = {s2_pld.sign, exp_fin[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
      if (any_nan || (any_inf && any_zero)) begin
         result_c = QNAN;
      end else if (any_inf || (!any_zero && exp_fin >= SEXP_INF)) begin
         result_c = {s2_pld.sign, POS_INF[WORD_W-2:0]};
      end else if (any_zero || exp_fin <= SEXP_ZERO) begin
         result_c = {s2_pld.sign, {(WORD_W-1){1'b0}}};
      end
   end

   fp32_pipe_slot #(.payload_t(logic [DataWidth-1:0])) u_slot_round (
      .clk      (clk),
      .aclr     (aclr),
      .in_valid (s2_vld),
      .in_data  (result_c),
      .in_rdy_c (s3_rdy_c),
      .out_valid(tail_vld[0]),
      .out_data (tail_pld[0]),
      .out_rdy  (tail_rdy_c[0])
   );

   assign tail_rdy_c[NUM_TAIL] = bus.DataOutRdy;

   for (genvar k = 1; k <= NUM_TAIL; k++) begin : g_tail
      fp32_pipe_slot #(.payload_t(logic [DataWidth-1:0])) u_slot_delay (
         .clk      (clk),
         .aclr     (aclr),
         .in_valid (tail_vld[k-1]),
         .in_data  (tail_pld[k-1]),
         .in_rdy_c (tail_rdy_c[k-1]),
         .out_valid(tail_vld[k]),
         .out_data (tail_pld[k]),
         .out_rdy  (tail_rdy_c[k])
      );
   end

   assign bus.DataOutValid = tail_vld[NUM_TAIL];
   assign bus.DataOut      = tail_pld[NUM_TAIL];

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Self-checking bench for fp32_mul_pipe: directed vectors, stall/reset
// sequences and randomized traffic against a real-arithmetic reference.
module tb_fp32_mul_pipe;

   logic clk = 1'b0;
   logic aclr;
   always #5 clk = ~clk;

   fp32_mul_pipe_if bus ();

   fp32_mul_pipe #(.DataWidth(32), .Pipeline_Stages(3)) dut (
      .clk (clk),
      .aclr(aclr),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_acc    = 0;
   int          n_out    = 0;
   logic [31:0] exp_q [$];
   logic        acc, fire;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %08h, required %08h", name, act, req);
      end
   endtask

   // Binary32 normal -> real, built through the binary64 encoding.
   function automatic real f2r(input logic [31:0] x);
      logic [63:0] d;
      d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'h0};
      return $bitstoreal(d);
   endfunction

   // Reference: exact product in binary64, then RNE to 24 bits with flush rules.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s, za, zb, ia, ib, na, nb;
      real         p;
      logic [63:0] d;
      logic [22:0] m;
      int          e;
      s  = a[31] ^ b[31];
      za = (a[30:23] == 8'h00);
      zb = (b[30:23] == 8'h00);
      ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
      ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
      na = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
      nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
      if (na || nb) return 32'h7FC0_0000;
      if ((ia && zb) || (za && ib)) return 32'h7FC0_0000;
      if (ia || ib) return {s, 8'hFF, 23'h0};
      if (za || zb) return {s, 31'h0};
      p = f2r(a) * f2r(b);
      d = $realtobits(p);
      e = int'(d[62:52]) - 1023 + 127;
      m = d[51:29];
      if (d[28] && ((d[27:0] != 28'h0) || m[0])) begin
         m = m + 23'd1;
         if (m == 23'h0) e++;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, 8'(e), m};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: ;
         1: case ($urandom_range(0, 5))
               0:       r = 32'h0000_0000;
               1:       r = 32'h8000_0000;
               2:       r = {r[31], 8'hFF, 23'h0};
               3:       r = {r[31], 8'hFF, r[22:0] | 23'h1};
               4:       r = {r[31], 8'h00, r[22:0]};
               default: r = {r[31], 8'h01, r[22:0]};
            endcase
         2: r[30:23] = 8'($urandom_range(190, 254));
         3: r[30:23] = 8'($urandom_range(1, 64));
         default: r[30:23] = 8'($urandom_range(100, 154));
      endcase
      return r;
   endfunction

   // One cycle: drive at negedge, sample settled handshake 1ns later.
   task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] y, input logic ordy);
      @(negedge clk);
      bus.DataInValid = v;
      bus.DataInA     = a;
      bus.DataInB     = b;
      bus.DataOutRdy  = ordy;
      #1;
      acc  = v && (bus.DataInRdy === 1'b1);
      fire = (bus.DataOutValid === 1'b1) && ordy;
      if (fire) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected output: got %08h, required no output", bus.DataOut);
         end else begin
            check("product", bus.DataOut, exp_q.pop_front());
         end
      end
      if (acc) begin
         exp_q.push_back(y);
         n_acc++;
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] y);
      int tries;
      tries = 0;
      do begin
         step(1'b1, a, b, y, 1'b1);
         tries++;
      end while (!acc && tries < 50);
      if (!acc) check("send accept", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1'b0, '0, '0, '0, 1'b1);
      check("drain empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, lat, sent, stale, outs0;
      logic [31:0] ra, rb;

      vecs[0]  = '{32'h43C8_8000, 32'h3F80_0000, 32'h43C8_8000};
      vecs[1]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
      vecs[2]  = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002};
      vecs[3]  = '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000};
      vecs[4]  = '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000};
      vecs[5]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000};
      vecs[6]  = '{32'hFFC0_0001, 32'h3F80_0000, 32'h7FC0_0000};
      vecs[7]  = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000};
      vecs[8]  = '{32'h3FFF_F830, 32'h3F80_03E8, 32'h4000_0000};
      vecs[9]  = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE};
      vecs[10] = '{32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF};
      vecs[11] = '{32'h0080_0000, 32'h3F80_0000, 32'h0080_0000};
      vecs[12] = '{32'hFF80_0000, 32'hC000_0000, 32'h7F80_0000};
      vecs[13] = '{32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0000};
      vecs[14] = '{32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000};
      vecs[15] = '{32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002};
      vecs[16] = '{32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004};

      bus.DataInValid = 1'b0;
      bus.DataInA     = '0;
      bus.DataInB     = '0;
      bus.DataOutRdy  = 1'b0;
      aclr            = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      aclr = 1'b0;
      #1;
      check("reset out valid", 32'(bus.DataOutValid), 32'd0);
      check("reset out data", bus.DataOut, 32'h0);
      check("reset in rdy", 32'(bus.DataInRdy), 32'd1);

      // Latency with an idle pipe and a ready consumer.
      step(1'b1, vecs[0].a, vecs[0].b, vecs[0].y, 1'b1);
      check("t1 accept", 32'(acc), 32'd1);
      lat = 0;
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         step(1'b0, '0, '0, '0, 1'b1);
         if (fire) lat = i;
      end
      check("t1 latency", 32'(lat), 32'd3);

      for (int i = 0; i < NVEC; i++) send(vecs[i].a, vecs[i].b, vecs[i].y);
      drain();

      // Full pipe under backpressure, then release.
      idx = 0;
      outs0 = n_out;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, vecs[1+idx].a, vecs[1+idx].b, vecs[1+idx].y, 1'b0);
         if (acc) idx++;
      end
      check("t4 accepted while stalled", 32'(idx), 32'd3);
      check("t4 in rdy full", 32'(bus.DataInRdy), 32'd0);
      check("t4 out valid", 32'(bus.DataOutValid), 32'd1);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, vecs[1+idx].a, vecs[1+idx].b, vecs[1+idx].y, 1'b0);
         check("t4 out held", bus.DataOut, vecs[1].y);
         check("t4 no accept while full", 32'(acc), 32'd0);
      end
      step(1'b1, vecs[1+idx].a, vecs[1+idx].b, vecs[1+idx].y, 1'b1);
      check("t4 accept on drain", 32'(acc), 32'd1);
      if (acc) idx++;
      for (int i = 0; i < 20 && idx < 5; i++) begin
         step(1'b1, vecs[1+idx].a, vecs[1+idx].b, vecs[1+idx].y, 1'b1);
         if (acc) idx++;
      end
      check("t4 all accepted", 32'(idx), 32'd5);
      drain();
      check("t4 outputs", 32'(n_out - outs0), 32'd5);

      // Randomized traffic with random valid/ready.
      ra = rand_op();
      rb = rand_op();
      sent = 0;
      for (int cyc = 0; cyc < 30000 && sent < 1000; cyc++) begin
         step(($urandom_range(0, 3) != 0), ra, rb, ref_mul(ra, rb), ($urandom_range(0, 3) != 0));
         if (acc) begin
            sent++;
            ra = rand_op();
            rb = rand_op();
         end
      end
      check("t5 pairs sent", 32'(sent), 32'd1000);
      drain();
      check("t5 out count", 32'(n_out), 32'(n_acc));

      // Reset with two items in flight.
      step(1'b1, vecs[1].a, vecs[1].b, vecs[1].y, 1'b0);
      step(1'b1, vecs[2].a, vecs[2].b, vecs[2].y, 1'b0);
      step(1'b0, '0, '0, '0, 1'b0);
      step(1'b0, '0, '0, '0, 1'b0);
      check("t6 out valid before reset", 32'(bus.DataOutValid), 32'd1);
      #2;
      aclr = 1'b1;
      #1;
      check("t6 out valid in reset", 32'(bus.DataOutValid), 32'd0);
      check("t6 out data in reset", bus.DataOut, 32'h0);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      aclr = 1'b0;
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, '0, '0, '0, 1'b1);
         if (fire) stale++;
      end
      check("t6 no stale output", 32'(stale), 32'd0);
      send(vecs[9].a, vecs[9].b, vecs[9].y);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
